// File: rtl/sys_wr_control.sv
// sys_wr_control: write-side address/enable sequencer for the systolic output
// memory. Produces a diagonal wavefront of per-lane write enables (growing for
// N cycles, shrinking for N-1) and per-lane row addresses starting at base_addr.
// Optional feature macro: SYS_WR_CONTROL_STRIDE_EN adds a row_stride input that
// replaces the fixed +1 address increment.
module sys_wr_control #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int ADDR_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    input  logic [ADDR_W-1:0]              base_addr,
`ifdef SYS_WR_CONTROL_STRIDE_EN
    input  logic [ADDR_W-1:0]              row_stride,
`endif
    output logic [WIDTH_HEIGHT-1:0]        wr_en,
    output logic [WIDTH_HEIGHT*ADDR_W-1:0] wr_addr,
    output logic                           busy,
    output logic                           done
);

    localparam int CNT_W = $clog2(2 * WIDTH_HEIGHT) + 1;
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(WIDTH_HEIGHT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(WIDTH_HEIGHT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [WIDTH_HEIGHT-1:0]          wr_en_q, wr_en_d;
    logic [WIDTH_HEIGHT*ADDR_W-1:0]   addr_q, addr_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic [ADDR_W-1:0]                step;

`ifdef SYS_WR_CONTROL_STRIDE_EN
    logic [ADDR_W-1:0]                stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    // Next-state logic: wavefront shaping, cycle counting and per-lane address advance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en_d = wr_en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SYS_WR_CONTROL_STRIDE_EN
        stride_d = stride_q;
`endif
        // a lane advances on the edge after each cycle it was enabled; this
        // also covers the final increment of the last lane on the done edge
        for (int unsigned i = 0; i < WIDTH_HEIGHT; i++) begin
            addr_d[i*ADDR_W +: ADDR_W] = addr_q[i*ADDR_W +: ADDR_W]
                                         + (wr_en_q[i] ? step : '0);
        end

        case (state_q)
            IDLE: begin
                if (active) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    wr_en_d = {{(WIDTH_HEIGHT-1){1'b0}}, 1'b1};
                    busy_d  = 1'b1;
                    addr_d  = {WIDTH_HEIGHT{base_addr}};
`ifdef SYS_WR_CONTROL_STRIDE_EN
                    stride_d = row_stride;
`endif
                end
            end
            FILL: begin
                if (cnt_q == FILL_LAST) begin
                    // leaving FILL already performs the first drain shift
                    state_d = DRAIN;
                    cnt_d   = '0;
                    wr_en_d = wr_en_q << 1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    wr_en_d = {wr_en_q[WIDTH_HEIGHT-2:0], 1'b1};
                end
            end
            DRAIN: begin
                wr_en_d = wr_en_q << 1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                wr_en_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; synchronous reset has priority over active
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_en_q  <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SYS_WR_CONTROL_STRIDE_EN
            stride_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SYS_WR_CONTROL_STRIDE_EN
            stride_q <= stride_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sys_wr_control.sv
// tb_sys_wr_control: directed bench for sys_wr_control (N=16, ADDR_W=8).
module tb_sys_wr_control;

    localparam int N  = 16;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            active;
    logic [AW-1:0]   base_addr;
`ifdef SYS_WR_CONTROL_STRIDE_EN
    logic [AW-1:0]   row_stride;
`endif
    logic [N-1:0]    wr_en;
    logic [N*AW-1:0] wr_addr;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sys_wr_control #(
        .WIDTH_HEIGHT(N),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .base_addr (base_addr),
`ifdef SYS_WR_CONTROL_STRIDE_EN
        .row_stride(row_stride),
`endif
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // lane i is enabled at edges k+1+i .. k+N+i (j counts edges after k)
    function automatic logic [N-1:0] exp_en(input int j);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = (j >= i + 1) && (j <= N + i);
        return v;
    endfunction

    // address = base + stride * (number of enabled cycles already completed)
    function automatic logic [N*AW-1:0] exp_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int j);
        logic [N*AW-1:0] v;
        int c;
        for (int i = 0; i < N; i++) begin
            c = j - 1 - i;
            if (c < 0) c = 0;
            if (c > N) c = N;
            v[i*AW +: AW] = b + AW'(int'(s) * c);
        end
        return v;
    endfunction

    // one full run starting with a request after the next edge; optional
    // stray pulses (pa/pb), held active, or reset asserted after edge rst_j
    task automatic run_check(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input int pa, input int pb, input bit hold, input int rst_j);
        @(posedge clk); #1;
        active    = 1'b1;
        base_addr = b;
`ifdef SYS_WR_CONTROL_STRIDE_EN
        row_stride = s;
`endif
        @(posedge clk); #1;
        active    = hold;
        base_addr = ~b;
`ifdef SYS_WR_CONTROL_STRIDE_EN
        row_stride = ~s;
`endif
        for (int j = 1; j <= 2 * N; j++) begin
            @(negedge clk);
            check_eq($sformatf("wr_en_j%0d", j), wr_en, exp_en(j));
            check_eq($sformatf("busy_j%0d", j), busy, (j < 2 * N));
            check_eq($sformatf("done_j%0d", j), done, (j == 2 * N));
            check_eq($sformatf("addr_j%0d", j), wr_addr, exp_addr(b, s, j));
            if (b == 8'h20 && s == 8'h01 && j == 16) begin
                check_eq("en_full", wr_en, 16'hFFFF);
                check_eq("lane15_first", wr_addr[15*AW +: AW], 8'h20);
            end
            if (b == 8'h20 && s == 8'h01 && j == 31) begin
                check_eq("en_last", wr_en, 16'h8000);
                check_eq("lane15_last", wr_addr[15*AW +: AW], 8'h2F);
                check_eq("lane0_final", wr_addr[7:0], 8'h30);
            end
            if (b == 8'hF8 && j == 9) check_eq("lane0_wrap", wr_addr[7:0], 8'h00);
            if (b == 8'h00 && s == 8'h04 && j == 4)  check_eq("lane3_stride_first", wr_addr[3*AW +: AW], 8'h00);
            if (b == 8'h00 && s == 8'h04 && j == 19) check_eq("lane3_stride_last", wr_addr[3*AW +: AW], 8'h3C);
            active = hold || (j == pa) || (j == pb);
            if (j == rst_j) begin
                reset = 1'b1;
                return;
            end
        end
    endtask

    task automatic check_idle(input string tag, input logic [N*AW-1:0] addr_exp);
        check_eq({tag, "_en"}, wr_en, '0);
        check_eq({tag, "_addr"}, wr_addr, addr_exp);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        active    = 1'b0;
        base_addr = '0;
`ifdef SYS_WR_CONTROL_STRIDE_EN
        row_stride = 8'h01;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // idle after reset
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_idle("idle", '0);
        end

        // basic run, base 0x20
        run_check(8'h20, 8'h01, 0, 0, 1'b0, 0);
        @(negedge clk);
        check_idle("after_run", {N{8'h30}});

        // wrap-around
        run_check(8'hF8, 8'h01, 0, 0, 1'b0, 0);
        check_eq("wrap_final", wr_addr, {N{8'h08}});

        // requests while busy are ignored
        run_check(8'h20, 8'h01, 5, 20, 1'b0, 0);
        @(negedge clk);
        check_idle("ignore_after", {N{8'h30}});

        // active held high: back-to-back restart right after done
        run_check(8'h20, 8'h01, 0, 0, 1'b1, 0);
        @(negedge clk);
        check_eq("b2b_en", wr_en, 16'h0001);
        check_eq("b2b_busy", busy, 1'b1);
        check_eq("b2b_done", done, 1'b0);
        check_eq("b2b_addr", wr_addr, {N{8'hDF}});
        active = 1'b0;
        repeat (2 * N + 2) @(negedge clk);
        check_idle("b2b_end", {N{8'hEF}});

        // reset mid-sequence
        run_check(8'h20, 8'h01, 0, 0, 1'b0, 10);
        @(negedge clk);
        check_idle("rst_mid", '0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle("rst_quiet", '0);
        end

        // fresh run after reset
        run_check(8'h20, 8'h01, 0, 0, 1'b0, 0);

`ifdef SYS_WR_CONTROL_STRIDE_EN
        run_check(8'h00, 8'h04, 0, 0, 1'b0, 0);
        run_check(8'h10, 8'h00, 0, 0, 1'b0, 0);
        check_eq("stride0_final", wr_addr, {N{8'h10}});
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
